ysyx_23060187_seq_ctrl: RTL

Multi-cycle instruction sequencer for the NPC core. It owns the PC and drives the instruction-fetch and load/store handshakes. It decodes opcode/fun3 and steps each instruction through FETCH → EXEC → (MEM) → WB. It emits the ALU control, operand selects and single-cycle write strobes to the existing datapath. It stops the core on ebreak, on an illegal opcode, or on a bus timeout.

---
 rtl/ysyx_23060187_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060187_seq_ctrl.sv
// Multi-cycle NPC sequencer: owns the PC and steps each instruction through
// FETCH -> IWAIT -> EXEC -> (MEM -> MWAIT) -> WB, stopping on ebreak, illegal op or bus timeout.
module ysyx_23060187_seq_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TO_W     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        inst_req,
   input  logic        inst_ready,
   input  logic        inst_rvalid,
   input  logic [31:0] inst_rdata,
   output logic        lsu_req,
   output logic        lsu_we,
   input  logic        lsu_ready,
   input  logic        lsu_rvalid,
   input  logic [31:0] alu_result,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic [3:0]  alu_ctrl,
   output logic        src_a_pc,
   output logic        src_b_imm,
   output logic [1:0]  wb_sel,
   output logic        rf_we,
   output logic        halt,
   output logic        illegal,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_IWAIT = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_MWAIT = 3'd4,
      S_WB    = 3'd5,
      S_STOP  = 3'd6
   } state_t;

   // Timeout when the counter would reach all-ones, i.e. on the (2^TO_W-1)th wait cycle.
   localparam logic [TO_W-1:0] CNT_LAST = {{(TO_W-1){1'b1}}, 1'b0};
   localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              halt_q, halt_d;
   logic              illegal_q, illegal_d;
   logic              bus_err_q, bus_err_d;
   logic              waiting;
   logic              in_dec;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic is_addi, is_auipc, is_lui, is_jal, is_jalr, is_lw, is_sw, is_ebreak;
   logic is_alu, is_mem;

   assign opcode    = inst_q[6:0];
   assign funct3    = inst_q[14:12];
   assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
   assign is_auipc  = (opcode == 7'b0010111);
   assign is_lui    = (opcode == 7'b0110111);
   assign is_jal    = (opcode == 7'b1101111);
   assign is_jalr   = (opcode == 7'b1100111) && (funct3 == 3'b000);
   assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
   assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
   assign is_ebreak = (inst_q == 32'h0010_0073);
   assign is_alu    = is_addi | is_auipc | is_lui | is_jal | is_jalr;
   assign is_mem    = is_lw | is_sw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         inst_q    <= 32'h0;
         cnt_q     <= '0;
         halt_q    <= 1'b0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         cnt_q     <= cnt_d;
         halt_q    <= halt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      cnt_d     = cnt_q;
      halt_d    = halt_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      waiting   = 1'b0;
      case (state_q)
         S_FETCH: begin
            waiting = 1'b1;
            if (inst_ready) state_d = S_IWAIT;
         end
         S_IWAIT: begin
            waiting = 1'b1;
            if (inst_rvalid) begin
               inst_d  = inst_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_alu) begin
               state_d = S_WB;
            end else if (is_mem) begin
               state_d = S_MEM;
            end else if (is_ebreak) begin
               halt_d  = 1'b1;
               state_d = S_STOP;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_STOP;
            end
         end
         S_MEM: begin
            waiting = 1'b1;
            if (lsu_ready) state_d = S_MWAIT;
         end
         S_MWAIT: begin
            waiting = 1'b1;
            if (lsu_rvalid) state_d = S_WB;
         end
         S_WB: begin
            if (is_jal)       pc_d = alu_result;
            else if (is_jalr) pc_d = {alu_result[31:1], 1'b0};
            else              pc_d = pc_q + 32'd4;
            state_d = S_FETCH;
         end
         S_STOP:  state_d = S_STOP;
         default: state_d = S_STOP;
      endcase
      if (waiting && (state_d == state_q)) begin
         if (cnt_q == CNT_LAST) begin
            bus_err_d = 1'b1;
            state_d   = S_STOP;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
      if (state_d != state_q) cnt_d = '0;
   end

   // Request gated by rst_n so nothing is presented while reset is held.
   always_comb begin
      in_dec    = (state_q == S_EXEC) || (state_q == S_MEM) ||
                  (state_q == S_MWAIT) || (state_q == S_WB);
      inst_req  = rst_n && (state_q == S_FETCH);
      lsu_req   = (state_q == S_MEM);
      lsu_we    = (state_q == S_MEM) && is_sw;
      rf_we     = (state_q == S_WB) && !is_sw;
      alu_ctrl  = (in_dec && (is_alu || is_mem)) ? 4'd2 : 4'd0;
      src_a_pc  = in_dec && (is_auipc || is_jal);
      src_b_imm = in_dec && (is_alu || is_mem);
      wb_sel    = 2'd0;
      if (in_dec && (is_jal || is_jalr)) wb_sel = 2'd1;
      else if (in_dec && is_lw)          wb_sel = 2'd2;
   end

   assign pc      = pc_q;
   assign inst    = inst_q;
   assign halt    = halt_q;
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

endmodule
